// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the serializer and sequence detector
package seq_pkg;
    typedef enum logic {
        SER_IDLE  = 1'b0,
        SER_SHIFT = 1'b1
    } ser_state_e;
    localparam int SER_WIDTH = 8;
    localparam logic [3:0] DET_PATTERN = 4'b1101;
endpackage

// File: rtl/seq_pend_buf.sv
// seq_pend_buf: one-entry pending word buffer in front of the serializer shift register
// Ports: clk, rst (sync, active-high); load/load_data write the slot,
// pop empties it; pend_data/pend_vld expose the slot; in_ready = slot empty.
module seq_pend_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pend_data,
    output logic             pend_vld,
    output logic             in_ready
);
    assign in_ready = !pend_vld;
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_vld  <= 1'b0;
            pend_data <= '0;
        end else if (load) begin
            pend_vld  <= 1'b1;
            pend_data <= load_data;
        end else if (pop) begin
            pend_vld  <= 1'b0;
        end
    end
endmodule

// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: parallel-to-serial front end for the sequence detector
// Ports: clk, rst (sync, active-high); in_valid/in_data/in_ready word handshake;
// hold stalls shifting; bit_out/bit_valid/last_bit serial stream; busy while
// shifting or a word is pending; words_done counts completed words (wraps).
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int WIDTH     = SER_WIDTH,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit IDLE_BIT  = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             hold,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             last_bit,
    output logic             busy,
    output logic [CNT_W-1:0] words_done
);
    localparam int IW = $clog2(WIDTH);
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);

    ser_state_e       state, state_n;
    logic [WIDTH-1:0] shreg, pend_data;
    logic [IW-1:0]    idx;
    logic             pend_vld, accept, done;
    logic             load_in, load_pend, shift, pend_load;

    seq_pend_buf #(.WIDTH(WIDTH)) u_pend (
        .clk       (clk),
        .rst       (rst),
        .load      (pend_load),
        .load_data (in_data),
        .pop       (load_pend),
        .pend_data (pend_data),
        .pend_vld  (pend_vld),
        .in_ready  (in_ready)
    );

    assign accept    = in_valid && in_ready;
    assign bit_valid = (state == SER_SHIFT) && !hold;
    assign done      = bit_valid && (idx == LAST);
    assign last_bit  = done;
    assign busy      = (state == SER_SHIFT) || pend_vld;
    assign bit_out   = bit_valid ? (MSB_FIRST ? shreg[WIDTH-1] : shreg[0]) : IDLE_BIT;

    // On completion a pending word wins over a same-cycle bypass; a word
    // arriving mid-word (or during hold) parks in the pending slot.
    always_comb begin
        state_n   = state;
        load_in   = 1'b0;
        load_pend = 1'b0;
        shift     = 1'b0;
        pend_load = 1'b0;
        if (state == SER_IDLE) begin
            load_in = accept;
            state_n = accept ? SER_SHIFT : SER_IDLE;
        end else if (done) begin
            load_pend = pend_vld;
            load_in   = !pend_vld && accept;
            state_n   = (pend_vld || accept) ? SER_SHIFT : SER_IDLE;
        end else begin
            shift     = bit_valid;
            pend_load = accept;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SER_IDLE;
            shreg      <= '0;
            idx        <= '0;
            words_done <= '0;
        end else begin
            state <= state_n;
            if (load_in || load_pend) begin
                shreg <= load_pend ? pend_data : in_data;
                idx   <= '0;
            end else if (shift) begin
                shreg <= MSB_FIRST ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
                idx   <= idx + 1'b1;
            end
            if (done)
                words_done <= words_done + 1'b1;
        end
    end
endmodule

// File: tb/tb_seq_bit_serializer.sv
// tb_seq_bit_serializer: directed self-checking bench for seq_bit_serializer
module tb_seq_bit_serializer;
    import seq_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_in_valid, a_in_ready, a_hold, a_bit_out, a_bit_valid, a_last_bit, a_busy;
    logic [3:0]  a_in_data, a_words_done;
    logic        b_in_valid, b_in_ready, b_hold, b_bit_out, b_bit_valid, b_last_bit, b_busy;
    logic [7:0]  b_in_data;
    logic [15:0] b_words_done;
    logic [3:0]  det_sr;
    int          n_checks = 0;
    int          n_errors = 0;

    always #5 clk = ~clk;

    seq_bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .CNT_W(4)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .hold(a_hold), .bit_out(a_bit_out), .bit_valid(a_bit_valid), .last_bit(a_last_bit),
        .busy(a_busy), .words_done(a_words_done)
    );

    seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0), .CNT_W(16)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .hold(b_hold), .bit_out(b_bit_out), .bit_valid(b_bit_valid), .last_bit(b_last_bit),
        .busy(b_busy), .words_done(b_words_done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        a_in_valid = 1'b0;
        a_hold     = 1'b0;
        b_in_valid = 1'b0;
        b_hold     = 1'b0;
        cyc();
        rst = 1'b0;
    endtask

    task automatic a_bit(input string tag, input logic b, input logic l);
        #1;
        check({tag, "_vld"}, a_bit_valid, 1);
        check({tag, "_bit"}, a_bit_out, b);
        check({tag, "_last"}, a_last_bit, l);
        det_sr = {det_sr[2:0], a_bit_out};
        cyc();
    endtask

    initial begin
        logic [3:0] w;
        logic [7:0] stream, rdy;
        int acc, bits;
        logic seen15;
        a_in_data = '0;
        b_in_data = '0;
        det_sr    = '0;

        do_reset();
        #1;
        check("rst_in_ready", a_in_ready, 1);
        check("rst_bit_valid", a_bit_valid, 0);
        check("rst_bit_out", a_bit_out, 0);
        check("rst_last", a_last_bit, 0);
        check("rst_busy", a_busy, 0);
        check("rst_words", a_words_done, 0);
        check("rst_b_in_ready", b_in_ready, 1);

        w = 4'b1101;
        a_in_valid = 1'b1;
        a_in_data  = w;
        cyc();
        a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) a_bit("t1", w[3-i], i == 3);
        #1;
        check("t1_words", a_words_done, 1);
        check("t1_detect", det_sr, DET_PATTERN);
        check("t1_idle_vld", a_bit_valid, 0);
        check("t1_idle_busy", a_busy, 0);

        do_reset();
        a_in_valid = 1'b1;
        a_in_data  = 4'hD;
        cyc();
        a_in_data = 4'h6;
        stream = 8'b1101_0110;
        rdy    = 8'b1000_1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t2_ready", a_in_ready, rdy[7-i]);
            a_bit("t2", stream[7-i], i == 3 || i == 7);
            if (i == 0) a_in_valid = 1'b0;
        end
        #1;
        check("t2_words", a_words_done, 2);
        check("t2_busy", a_busy, 0);

        do_reset();
        a_in_valid = 1'b1;
        a_in_data  = 4'b1011;
        cyc();
        a_in_valid = 1'b0;
        a_bit("t3a", 1, 0);
        a_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t3_hold_vld", a_bit_valid, 0);
            check("t3_hold_bit", a_bit_out, 0);
            check("t3_hold_last", a_last_bit, 0);
            check("t3_hold_busy", a_busy, 1);
            cyc();
        end
        a_hold = 1'b0;
        a_bit("t3b", 0, 0);
        a_bit("t3c", 1, 0);
        a_bit("t3d", 1, 1);
        #1;
        check("t3_words", a_words_done, 1);
        check("t3_end_vld", a_bit_valid, 0);

        do_reset();
        a_in_valid = 1'b1;
        a_in_data  = 4'hD;
        cyc();
        a_in_valid = 1'b0;
        a_bit("t4a", 1, 0);
        a_bit("t4b", 1, 0);
        a_bit("t4c", 0, 0);
        a_in_valid = 1'b1;
        a_in_data  = 4'h6;
        a_bit("t4d", 1, 1);
        a_in_valid = 1'b0;
        a_bit("t4e", 0, 0);
        a_bit("t4f", 1, 0);
        a_bit("t4g", 1, 0);
        a_bit("t4h", 0, 1);
        #1;
        check("t4_words", a_words_done, 2);

        do_reset();
        a_in_valid = 1'b1;
        a_in_data  = 4'hD;
        cyc();
        a_in_data = 4'h6;
        a_bit("t5a", 1, 0);
        a_in_valid = 1'b0;
        #1;
        check("t5_pend_ready", a_in_ready, 0);
        check("t5_pend_busy", a_busy, 1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        check("t5_rst_vld", a_bit_valid, 0);
        check("t5_rst_busy", a_busy, 0);
        check("t5_rst_ready", a_in_ready, 1);
        check("t5_rst_words", a_words_done, 0);
        a_in_valid = 1'b1;
        a_in_data  = 4'h9;
        cyc();
        a_in_valid = 1'b0;
        a_bit("t5b", 1, 0);
        a_bit("t5c", 0, 0);
        a_bit("t5d", 0, 0);
        a_bit("t5e", 1, 1);
        #1;
        check("t5_words", a_words_done, 1);
        check("t5_no_stale", a_bit_valid, 0);

        do_reset();
        a_in_valid = 1'b1;
        a_in_data  = 4'hA;
        acc    = 0;
        bits   = 0;
        seen15 = 1'b0;
        for (int c = 0; c < 200 && (acc < 16 || a_busy); c++) begin
            #1;
            if (a_in_valid && a_in_ready) acc++;
            if (a_bit_valid) bits++;
            if (a_words_done == 4'hF) seen15 = 1'b1;
            cyc();
            if (acc == 16) a_in_valid = 1'b0;
        end
        #1;
        check("t6_accepted", acc, 16);
        check("t6_bits", bits, 64);
        check("t6_seen15", seen15, 1);
        check("t6_wrap", a_words_done, 0);
        check("t6_busy", a_busy, 0);

        b_in_valid = 1'b1;
        b_in_data  = 8'h01;
        cyc();
        b_in_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("t7_vld", b_bit_valid, 1);
            check("t7_bit", b_bit_out, i == 0);
            check("t7_last", b_last_bit, i == 7);
            cyc();
        end
        #1;
        check("t7_words", b_words_done, 1);
        check("t7_busy", b_busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Parallel-to-serial front end feeding the Mealy sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on bit_out, which connects to the detector's serial input.
- Has a one-word pending buffer, so back-to-back words stream with no idle gap.
- Supports a hold (stall) input and a completed-word counter.

Parameters:
- WIDTH, 8, bits per input word (legal range 2..32).
- MSB_FIRST, 1, 1 = transmit in_data[WIDTH-1] first; 0 = transmit in_data[0] first.
- IDLE_BIT, 0, value driven on bit_out whenever bit_valid is low.
- CNT_W, 16, width of the words_done counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  in_data holds a word to send.
- in_data  input  WIDTH  word to serialize.
- in_ready  output  1  block can take a word this cycle.
- hold  input  1  stall; freezes shifting while high.
- bit_out  output  1  serial bit to the detector.
- bit_valid  output  1  bit_out carries a real data bit this cycle.
- last_bit  output  1  bit_out is the final bit of the current word.
- busy  output  1  state is SHIFT or a word is pending.
- words_done  output  CNT_W  count of fully transmitted words.

Behaviour:
- Interface timing:
  - One clock (clk); reset is synchronous and active-high on rst.
  - All state is updated only on the rising edge of clk.
- Registers:
  - shreg[WIDTH]: shift register.
  - idx: bit index, 0..WIDTH-1.
  - pend_data[WIDTH] and pend_vld: one-word pending buffer.
  - state: IDLE or SHIFT.
  - words_done.
- Reset (rst=1 at an edge): state=IDLE, pend_vld=0, idx=0, words_done=0. Any word in flight or pending is discarded, with no partial completion.
- Outputs after reset: in_ready=1, bit_valid=0, bit_out=IDLE_BIT, last_bit=0, busy=0, words_done=0.
- Handshake:
  - in_ready = !pend_vld (combinational). A word is accepted at the edge where in_valid && in_ready.
  - in_data must be held stable while in_valid=1 && in_ready=0.
- Output decode (combinational from registers and hold):
  - bit_valid = (state==SHIFT) && !hold.
  - bit_out = bit_valid ? current bit : IDLE_BIT. The current bit is shreg[WIDTH-1] when MSB_FIRST=1, else shreg[0].
  - last_bit = bit_valid && (idx==WIDTH-1).
  - busy = (state==SHIFT) || pend_vld.
- IDLE, accept: shreg<=in_data, idx<=0, state<=SHIFT. The first bit is on bit_out in the cycle after the accepting edge (latency 1).
- SHIFT, edge with bit_valid=1 and idx<WIDTH-1: shift shreg one place toward the output end, idx<=idx+1.
  - If a word is accepted this edge, it goes to pend_data and pend_vld<=1.
- SHIFT, edge with bit_valid=1 and idx==WIDTH-1 (word completes): words_done<=words_done+1, wrapping modulo 2^CNT_W. Then, by priority:
  - (a) pend_vld=1: shreg<=pend_data, pend_vld<=0, idx<=0, stay in SHIFT.
  - (b) else, if a word is accepted this edge: load in_data directly into shreg (bypass), idx<=0, stay in SHIFT.
  - (c) else: state<=IDLE.
  - Net effect: consecutive words are emitted gap-free, WIDTH bits per WIDTH cycles.
- hold=1:
  - No shift and no idx change; bit_valid=0.
  - Acceptance into an empty pending slot still proceeds.
  - When hold falls, the frozen bit is re-presented; no bit is ever skipped or duplicated on bit_valid.
- Pending slot full and shifting: in_ready=0, so a new word stalls upstream. in_ready returns to 1 the cycle after the pending word moves into shreg.
- rst has priority over every other event in the same cycle, including accept, hold and word completion.

Decomposition:
- Shared package seq_pkg:
  - state encoding constants: SER_IDLE=1'b0, SER_SHIFT=1'b1.
  - default WIDTH.
  - the 4-bit detector pattern constant 4'b1101, shared with the detector's testbench.
- One sub-module is natural: seq_pend_buf, the one-entry pending buffer. It holds pend_data/pend_vld, drives in_ready, and has load/pop controls.
- The FSM, shift register and counter stay in the top module.

Test Plan:
1. WIDTH=4, MSB_FIRST=1. Accept 4'b1101 at edge 0 -> bit_out = 1,1,0,1 in cycles 1-4, last_bit only in cycle 4. words_done=1 after edge 4. The detector downstream pulses when the final 1 is shifted in.
2. Back-to-back: 4'hD then 4'h6, both offered while busy -> 8 consecutive bit_valid cycles with stream 1101 0110. in_ready is low only while the pending slot is full. words_done=2.
3. hold asserted in cycle 2 of 4'b1011 for 3 cycles -> bit_valid=0 and bit_out=IDLE_BIT during hold. The stream resumes with the frozen bit: 1,0,1,1, no loss or repeat.
4. Bypass: offer a new word exactly in the last-bit cycle with the pending slot empty -> the next cycle shows bit 0 of the new word, with no IDLE gap.
5. rst asserted mid-word, with a word also pending -> next cycle: bit_valid=0, busy=0, in_ready=1, words_done=0. A subsequently accepted word is sent in full.
6. MSB_FIRST=0, WIDTH=8, word 8'h01 -> bit_out = 1,0,0,0,0,0,0,0. Also preload words_done to all-ones via 2^CNT_W words (CNT_W=4 build) and check it wraps to 0.
